// File: rtl/canny_pkg.sv
// Shared types for the Canny edge pipeline.
//
// Contents:
//   PIX_W, ANG_W : magnitude and gradient-direction widths
//   CLS_W, cls_e : 2-bit pixel class (NONE / WEAK / STRONG)
//   col_t        : one 3-high column of classes in the hysteresis window
//   state_e      : hysteresis sequencing states
//   classify()   : double-threshold classification of one magnitude
package canny_pkg;

    localparam int PIX_W = 5;
    localparam int ANG_W = 2;
    localparam int CLS_W = 2;

    typedef enum logic [CLS_W-1:0] {
        ClsNone   = 2'b00,
        ClsWeak   = 2'b01,
        ClsStrong = 2'b10
    } cls_e;

    // One window column: top = row above centre, bot = row below centre.
    typedef struct packed {
        cls_e top;
        cls_e mid;
        cls_e bot;
    } col_t;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StRun,
        StFlush
    } state_e;

    function automatic cls_e classify(input logic [PIX_W-1:0] px,
                                      input logic [PIX_W-1:0] th_high,
                                      input logic [PIX_W-1:0] th_low);
        cls_e cls;
        cls = ClsNone;
        if (px >= th_high) begin
            cls = ClsStrong;
        end else if (px >= th_low) begin
            cls = ClsWeak;
        end
        return cls;
    endfunction

endpackage

// File: rtl/hyst_threshold_line_buf.sv
// hyst_line_buf: DEPTH-deep shift register of 2-bit pixel classes.
// cls_o is the class shifted in DEPTH shifts ago (one image row of delay).
//
// Ports:
//   clk_p_i    : clock, rising edge
//   reset_n_i  : asynchronous active-low reset, clears contents to NONE
//   shift_en_i : shift one position this cycle
//   cls_i      : class entering the buffer
//   cls_o      : oldest class (leaves on the next shift)
module hyst_line_buf
    import canny_pkg::*;
#(
    parameter int unsigned DEPTH = 10
) (
    input  logic             clk_p_i,
    input  logic             reset_n_i,
    input  logic             shift_en_i,
    input  logic [CLS_W-1:0] cls_i,
    output logic [CLS_W-1:0] cls_o
);

    logic [CLS_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= ClsNone;
            end
        end else if (shift_en_i) begin
            mem_q[0] <= cls_i;
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign cls_o = mem_q[DEPTH-1];

endmodule

// File: rtl/hyst_threshold.sv
// hyst_threshold: double threshold + single-pass 8-neighbour hysteresis on the
// thinned magnitude stream from nonMax. Emits a 1-bit edge map in raster order
// with a latency of IMG_W+1 accepts, and flushes the last IMG_W+1 pixels of each
// frame by itself (busy_o high, inputs ignored).
//
// Optional build macro HYST_THR_PORT_EN: adds th_high_i / th_low_i, sampled on
// the first accept of a frame and held for the frame (HIGH_TH / LOW_TH unused).
//
// Ports:
//   clk_p_i      : clock, rising edge
//   reset_n_i    : asynchronous active-low reset (aborts the frame)
//   pixel_in_i   : NMS magnitude
//   enable_i     : pixel_in_i valid
//   th_high_i    : strong threshold (HYST_THR_PORT_EN only)
//   th_low_i     : weak threshold (HYST_THR_PORT_EN only)
//   edge_o       : edge decision for the current output pixel
//   readable_o   : edge_o valid this cycle
//   busy_o       : flushing; enable_i ignored
//   frame_done_o : pulses with the last output of a frame
module hyst_threshold
    import canny_pkg::*;
#(
    parameter int unsigned IMG_W   = 10,
    parameter int unsigned IMG_H   = 10,
    parameter int unsigned HIGH_TH = 20,
    parameter int unsigned LOW_TH  = 10
) (
    input  logic             clk_p_i,
    input  logic             reset_n_i,
    input  logic [PIX_W-1:0] pixel_in_i,
    input  logic             enable_i,
`ifdef HYST_THR_PORT_EN
    input  logic [PIX_W-1:0] th_high_i,
    input  logic [PIX_W-1:0] th_low_i,
`endif
    output logic             edge_o,
    output logic             readable_o,
    output logic             busy_o,
    output logic             frame_done_o
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);

    state_e           state_q, state_d;
    logic [COL_W-1:0] in_col_q, in_col_d, out_col_q, out_col_d;
    logic [ROW_W-1:0] in_row_q, in_row_d, out_row_q, out_row_d;
    col_t             win_ctr_q, win_left_q, new_col;
    logic             edge_q, readable_q, done_q;

    logic             accept, step, emit;
    logic             in_last_col, in_last_row, out_last_col, out_last_row;
    logic             last_in, last_out;
    logic [PIX_W-1:0] th_high, th_low;
    cls_e             in_cls;
    logic [CLS_W-1:0] lb0_cls, lb1_cls;
    logic             has_up, has_dn, has_lt, has_rt, strong_nb, edge_d;

    assign busy_o = (state_q == StFlush);
    assign accept = enable_i && !busy_o;
    // Flush cycles advance the pipeline as if a NONE pixel had arrived.
    assign step   = accept || busy_o;
    assign emit   = (accept && (state_q == StRun)) || busy_o;

    assign in_last_col  = (in_col_q == COL_W'(IMG_W - 1));
    assign in_last_row  = (in_row_q == ROW_W'(IMG_H - 1));
    assign out_last_col = (out_col_q == COL_W'(IMG_W - 1));
    assign out_last_row = (out_row_q == ROW_W'(IMG_H - 1));
    assign last_in      = in_last_col && in_last_row;
    assign last_out     = out_last_col && out_last_row;

`ifdef HYST_THR_PORT_EN
    logic [PIX_W-1:0] th_high_q, th_low_q;

    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            th_high_q <= '0;
            th_low_q  <= '0;
        end else if (accept && (state_q == StIdle)) begin
            th_high_q <= th_high_i;
            th_low_q  <= th_low_i;
        end
    end

    // The frame's first pixel is classified with the values being sampled.
    assign th_high = (state_q == StIdle) ? th_high_i : th_high_q;
    assign th_low  = (state_q == StIdle) ? th_low_i  : th_low_q;
`else
    assign th_high = PIX_W'(HIGH_TH);
    assign th_low  = PIX_W'(LOW_TH);
`endif

    assign in_cls = busy_o ? ClsNone : classify(pixel_in_i, th_high, th_low);

    hyst_line_buf #(
        .DEPTH (IMG_W)
    ) u_lb0 (
        .clk_p_i    (clk_p_i),
        .reset_n_i  (reset_n_i),
        .shift_en_i (step),
        .cls_i      (in_cls),
        .cls_o      (lb0_cls)
    );

    hyst_line_buf #(
        .DEPTH (IMG_W)
    ) u_lb1 (
        .clk_p_i    (clk_p_i),
        .reset_n_i  (reset_n_i),
        .shift_en_i (step),
        .cls_i      (lb0_cls),
        .cls_o      (lb1_cls)
    );

    // 3x3 window = {win_left_q, win_ctr_q, new_col}. new_col is the right-hand
    // column formed by the incoming pixel and the two line-buffer taps, so the
    // decision for the centre pixel is ready at the accept edge.
    always_comb begin
        new_col     = '{top: ClsNone, mid: ClsNone, bot: ClsNone};
        new_col.top = cls_e'(lb1_cls);
        new_col.mid = cls_e'(lb0_cls);
        new_col.bot = in_cls;
    end

    // Neighbour masks derived from the output (centre) position. Masked
    // columns/rows may hold stale or wrapped data, which is never looked at.
    always_comb begin
        has_up    = (out_row_q != '0);
        has_dn    = !out_last_row;
        has_lt    = (out_col_q != '0);
        has_rt    = !out_last_col;
        strong_nb = 1'b0;
        if (has_lt) begin
            strong_nb = strong_nb || (has_up && (win_left_q.top == ClsStrong))
                                  || (win_left_q.mid == ClsStrong)
                                  || (has_dn && (win_left_q.bot == ClsStrong));
        end
        strong_nb = strong_nb || (has_up && (win_ctr_q.top == ClsStrong))
                              || (has_dn && (win_ctr_q.bot == ClsStrong));
        if (has_rt) begin
            strong_nb = strong_nb || (has_up && (new_col.top == ClsStrong))
                                  || (new_col.mid == ClsStrong)
                                  || (has_dn && (new_col.bot == ClsStrong));
        end
        edge_d = (win_ctr_q.mid == ClsStrong) || ((win_ctr_q.mid == ClsWeak) && strong_nb);
    end

    always_comb begin
        state_d   = state_q;
        in_col_d  = in_col_q;
        in_row_d  = in_row_q;
        out_col_d = out_col_q;
        out_row_d = out_row_q;

        if (accept) begin
            if (in_last_col) begin
                in_col_d = '0;
                in_row_d = in_last_row ? '0 : in_row_q + ROW_W'(1);
            end else begin
                in_col_d = in_col_q + COL_W'(1);
            end
        end

        if (emit) begin
            if (out_last_col) begin
                out_col_d = '0;
                out_row_d = out_last_row ? '0 : out_row_q + ROW_W'(1);
            end else begin
                out_col_d = out_col_q + COL_W'(1);
            end
        end

        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StFill;
            end
            StFill: begin
                // Accept k = IMG_W: row 1, col 0.
                if (accept && (in_row_q == ROW_W'(1)) && (in_col_q == '0)) state_d = StRun;
            end
            StRun: begin
                if (accept && last_in) state_d = StFlush;
            end
            StFlush: begin
                if (last_out) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= StIdle;
            in_col_q   <= '0;
            in_row_q   <= '0;
            out_col_q  <= '0;
            out_row_q  <= '0;
            win_ctr_q  <= '{top: ClsNone, mid: ClsNone, bot: ClsNone};
            win_left_q <= '{top: ClsNone, mid: ClsNone, bot: ClsNone};
            edge_q     <= 1'b0;
            readable_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_col_q   <= in_col_d;
            in_row_q   <= in_row_d;
            out_col_q  <= out_col_d;
            out_row_q  <= out_row_d;
            if (step) begin
                win_left_q <= win_ctr_q;
                win_ctr_q  <= new_col;
            end
            readable_q <= emit;
            edge_q     <= emit && edge_d;
            done_q     <= emit && last_out;
        end
    end

    assign edge_o       = edge_q;
    assign readable_o   = readable_q;
    assign frame_done_o = done_q;

endmodule

// File: tb/tb_hyst_threshold.sv
// Scoreboard bench for hyst_threshold: a reference edge map is computed per
// pixel as it is driven, queued, and popped as outputs appear.
module tb_hyst_threshold;

    localparam int unsigned W  = 10;
    localparam int unsigned H  = 10;
    localparam int unsigned N  = W * H;
    localparam int unsigned HI = 20;
    localparam int unsigned LO = 10;

    logic       clk_p_i    = 1'b0;
    logic       reset_n_i  = 1'b0;
    logic       enable_i   = 1'b0;
    logic [4:0] pixel_in_i = '0;
    logic       edge_o, readable_o, busy_o, frame_done_o;
`ifdef HYST_THR_PORT_EN
    logic [4:0] th_high_i = 5'(HI);
    logic [4:0] th_low_i  = 5'(LO);
`endif

    hyst_threshold #(
        .IMG_W   (W),
        .IMG_H   (H),
        .HIGH_TH (HI),
        .LOW_TH  (LO)
    ) dut (
        .clk_p_i      (clk_p_i),
        .reset_n_i    (reset_n_i),
        .pixel_in_i   (pixel_in_i),
        .enable_i     (enable_i),
`ifdef HYST_THR_PORT_EN
        .th_high_i    (th_high_i),
        .th_low_i     (th_low_i),
`endif
        .edge_o       (edge_o),
        .readable_o   (readable_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk_p_i = ~clk_p_i;

    typedef struct packed {
        logic e;
        logic d;
    } exp_t;

    exp_t        exp_q [$];
    logic [4:0]  img [N];
    logic        out_map [N];
    int unsigned model_hi = HI;
    int unsigned model_lo = LO;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          out_cnt, done_cnt, busy_out_cnt, acc_cnt, first_rd_cyc, acc12_cyc;
    logic        step_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int cls_of(input int r, input int c);
        if (img[r*W+c] >= model_hi) return 2;
        if (img[r*W+c] >= model_lo) return 1;
        return 0;
    endfunction

    function automatic logic ref_edge(input int r, input int c);
        int ctr;
        ctr = cls_of(r, c);
        if (ctr == 2) return 1'b1;
        if (ctr != 1) return 1'b0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < int'(H) &&
                    c + dc >= 0 && c + dc < int'(W)) begin
                    if (cls_of(r + dr, c + dc) == 2) return 1'b1;
                end
            end
        end
        return 1'b0;
    endfunction

    function automatic int ones();
        int n = 0;
        for (int i = 0; i < int'(N); i++) n += int'(out_map[i]);
        return n;
    endfunction

    always @(posedge clk_p_i) cyc <= cyc + 1;

    // Output monitor, sampled mid-cycle.
    always @(negedge clk_p_i) begin
        if (!reset_n_i) begin
            step_prev = 1'b0;
        end else begin
            if (readable_o) begin
                exp_t x;
                check("rd_follows_step", step_prev, 1);
                check("q_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    x = exp_q.pop_front();
                    check("edge", edge_o, x.e);
                    check("frame_done", frame_done_o, x.d);
                end
                if (out_cnt == 0) first_rd_cyc = cyc;
                if (out_cnt < int'(N)) out_map[out_cnt] = edge_o;
                out_cnt++;
                if (frame_done_o) done_cnt++;
                if (busy_o) busy_out_cnt++;
            end else if (frame_done_o) begin
                check("done_needs_rd", readable_o, 1);
            end
            if (enable_i && !busy_o) begin
                acc_cnt++;
                if (acc_cnt == 12) acc12_cyc = cyc + 1;
            end
            step_prev = busy_o || enable_i;
        end
    end

    task automatic send_pixels(input int count, input bit toggle);
        for (int k = 0; k < count; k++) begin
            @(posedge clk_p_i);
            #1;
`ifdef HYST_THR_PORT_EN
            if (k == 0) begin
                th_high_i = 5'(model_hi);
                th_low_i  = 5'(model_lo);
            end else if (k == 5) begin
                th_high_i = 5'd31;
                th_low_i  = 5'd31;
            end
`endif
            enable_i   = 1'b1;
            pixel_in_i = img[k];
            exp_q.push_back('{e: ref_edge(k / int'(W), k % int'(W)), d: (k == int'(N) - 1)});
            if (toggle) begin
                @(posedge clk_p_i);
                #1;
                enable_i   = 1'b0;
                pixel_in_i = 5'h1f;
            end
        end
        @(posedge clk_p_i);
        #1;
        enable_i = 1'b0;
    endtask

    task automatic clear_counts();
        out_cnt = 0; done_cnt = 0; busy_out_cnt = 0; acc_cnt = 0;
        first_rd_cyc = -1; acc12_cyc = -2;
        for (int i = 0; i < int'(N); i++) out_map[i] = 1'bx;
    endtask

    task automatic run_frame(input string name, input bit toggle);
        int n = 0;
        clear_counts();
        send_pixels(int'(N), toggle);
        while ((exp_q.size() != 0 || busy_o) && n < 400) begin
            @(posedge clk_p_i);
            #1;
            n++;
        end
        repeat (3) @(posedge clk_p_i);
        #1;
        check({name, "_drained"}, n < 400, 1);
        check({name, "_outputs"}, out_cnt, N);
        check({name, "_done_pulses"}, done_cnt, 1);
        check({name, "_busy_outputs"}, busy_out_cnt, W + 1);
    endtask

    task automatic fill(input logic [4:0] v);
        for (int i = 0; i < int'(N); i++) img[i] = v;
    endtask

    initial begin
        clear_counts();
        fill(5'd0);
        repeat (3) @(posedge clk_p_i);
        #1;
        check("rst_edge", edge_o, 0);
        check("rst_readable", readable_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", frame_done_o, 0);
        reset_n_i = 1'b1;

        // All strong: every output is an edge.
        fill(5'd25);
        run_frame("all25", 1'b0);
        check("first_rd_latency", first_rd_cyc, acc12_cyc);
        check("all25_ones", ones(), N);

        // Isolated weak pixel.
        fill(5'd0);
        img[4*W+4] = 5'd15;
        run_frame("iso_weak", 1'b0);
        check("iso_weak_ones", ones(), 0);

        // Weak with a diagonal strong neighbour.
        fill(5'd0);
        img[2*W+3] = 5'd15;
        img[3*W+4] = 5'd25;
        run_frame("diag", 1'b0);
        check("diag_out23", out_map[23], 1);
        check("diag_out34", out_map[34], 1);
        check("diag_ones", ones(), 2);

        // Same image with a bubble after every accept.
        run_frame("diag_toggle", 1'b1);
        check("tog_out23", out_map[23], 1);
        check("tog_out34", out_map[34], 1);
        check("tog_ones", ones(), 2);

        // No horizontal wrap between row end and next row start.
        fill(5'd0);
        img[1*W+9] = 5'd25;
        img[2*W+0] = 5'd15;
        run_frame("nowrap", 1'b0);
        check("nowrap_out19", out_map[19], 1);
        check("nowrap_out20", out_map[20], 0);
        check("nowrap_ones", ones(), 1);

        // Reset in the middle of row 5, then a clean frame.
        fill(5'd25);
        clear_counts();
        send_pixels(55, 1'b0);
        reset_n_i = 1'b0;
        #1;
        check("midrst_edge", edge_o, 0);
        check("midrst_readable", readable_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_done", frame_done_o, 0);
        exp_q.delete();
        repeat (2) @(posedge clk_p_i);
        #1;
        reset_n_i = 1'b1;
        run_frame("after_rst", 1'b0);
        check("after_rst_ones", ones(), N);

`ifdef HYST_THR_PORT_EN
        // Thresholds sampled at frame start; the mid-frame change must not apply.
        model_hi = 8;
        model_lo = 4;
        fill(5'd9);
        run_frame("thr_port", 1'b0);
        check("thr_port_ones", ones(), N);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule
